icache_l1_gen2: RTL and testbench
=================================

ICACHE_L1_GEN2 -- requirements
Module: icache_l1_gen2

Interface
REQ-001 Parameter S, default 32, number of sets (power of 2, >=2).
REQ-002 Parameter E, default 4, ways per set (power of 2, >=2).
REQ-003 Parameter B, default 64, block size in bytes (power of 2, >=8).
REQ-004 Parameter RW, default 64, refill beat width in bits (power of 2, 32 <= RW <= B*8).
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 pc_f_i  in  32  fetch address: tag = [31:s+b], set = [s+b-1:b], byte offset = [b-1:0], with s=log2 S and b=log2 B.
REQ-008 pc_src_reg_i  in  2  nonzero means a fetch redirect is in progress.
REQ-009 flush_i  in  1  one-cycle pulse that invalidates the whole cache (fence.i).
REQ-010 mem_req_ready_i  in  1  memory accepts the pending refill request.
REQ-011 rep_valid_i  in  1  rep_word_i carries a valid refill beat this cycle.
REQ-012 rep_word_i  in  RW  refill beat; beats arrive in ascending address order.
REQ-013 instr_f_o  out  32  instruction word at pc_f_i[b-1:2] of the hit way.
REQ-014 instr_miss_f_o  out  1  no valid tag match, or a refill is in progress.
REQ-015 instr_cache_rep_active_o  out  1  the FSM is not in IDLE.
REQ-016 mem_req_o  out  1  refill request valid.
REQ-017 mem_addr_o  out  32  block-aligned miss address (pc_f_i with the low b bits zeroed).

Function
REQ-018 Lookup is combinational.
- Hit = some way in the indexed set is valid and its tag equals pc_f_i[31:s+b].
- instr_f_o and instr_miss_f_o are valid in the same cycle as pc_f_i.
- instr_f_o is 0 on a miss.
REQ-019 The FSM has three states: IDLE, REQ and FILL.
- IDLE -> REQ on a miss with flush_i = 0. The miss address and the victim way are latched.
- REQ -> FILL when mem_req_ready_i = 1.
- FILL -> IDLE on the cycle the last beat is accepted.
REQ-020 In REQ, mem_req_o = 1 and mem_addr_o holds the latched address, stable until accepted.
REQ-021 In REQ, pc_src_reg_i != 0 with mem_req_ready_i = 0 cancels the request: next state IDLE, no array change. If mem_req_ready_i = 1 in the same cycle, acceptance wins.
REQ-022 FILL beat handling:
- Each beat with rep_valid_i = 1 is written to beat slot cnt of the victim block, then cnt increments.
- cnt is log2(B*8/RW) bits wide and wraps to 0.
- Cycles with rep_valid_i = 0 are stalls. rep_valid_i outside FILL is ignored.
REQ-023 On the last beat, the victim's tag is written and it is marked valid. Lookups see it from the next cycle. Redirects during FILL do not abort the fill.
REQ-024 Victim selection: the lowest-index invalid way; otherwise the way with the maximum LRU age.
REQ-025 LRU ages are log2(E) bits per way per set and form a permutation of 0..E-1 within each set. On a hit in IDLE, and on fill completion, the touched way's age becomes 0 and every way in that set with a smaller age increments.
REQ-026 instr_miss_f_o = 1 whenever the state is not IDLE, regardless of tag match.
REQ-027 Flush behaviour:
- flush_i in IDLE clears every valid bit at the next edge and resets every set's ages to age[w] = w. The current cycle's miss does not start a request.
- flush_i in REQ or FILL sets a pending flag. It is applied on the cycle the FSM returns to IDLE, after the fill's tag and valid write.

Reset
REQ-028 While reset_i = 1:
- state = IDLE, cnt = 0, pending flush = 0.
- All valid bits = 0; ages set to age[w] = w.
- mem_req_o = 0, mem_addr_o = 0.
REQ-029 Reset asserted mid-REQ or mid-FILL abandons the operation: the partial block is never marked valid. After reset, instr_miss_f_o = 1 for every address.
REQ-030 The data and tag arrays are not reset.

Structure
REQ-031 Package icache_pkg holds the FSM state enum (IDLE, REQ, FILL) and shared parameter-check constants. An elaboration assertion rejects illegal S, E, B or RW.
REQ-032 Sub-module icache_l1_lru holds one set's ages and provides the victim and update logic. It is instantiated once per set, or one shared instance is used with a per-set age array.

Verification
REQ-033 S=32, E=4, B=64, RW=64, after reset: pc_f_i=0x0000_0000 -> miss=1; mem_req_o with mem_addr_o=0x0 next cycle; 8 beats; then reads of offsets 0..60 return the beat data with miss=0.
REQ-034 Same setup with RW=128: the fill completes after exactly 4 beats. Alternate rep_valid_i stalls (1,0,1,0...) -> the same data, and active=1 for the whole fill.
REQ-035 Fill all 4 ways of set 3, hit ways 0,1,2, then miss a new tag -> way 3 is replaced; way 0 still hits.
REQ-036 pc_src_reg_i=2'b01 in REQ with ready=0 -> IDLE next cycle and no valid bit set; the same pc misses again.
REQ-037 flush_i during beat 5 of 8 -> the fill completes; the cycle after, all ways miss, including the just-filled block.
REQ-038 reset_i during FILL beat 3 -> state IDLE and miss=1 for that address; a refetch performs a full 8-beat fill.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the L1 instruction cache: refill FSM states and
// the legality rules for the cache geometry parameters.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_state_e;

  localparam int MIN_SETS        = 2;
  localparam int MIN_WAYS        = 2;
  localparam int MIN_BLOCK_BYTES = 8;
  localparam int MIN_BEAT_BITS   = 32;
  localparam int INSTR_BITS      = 32;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // A beat can never be wider than a whole block.
  function automatic bit params_ok(input int s, input int e, input int b, input int rw);
    return is_pow2(s) && (s >= MIN_SETS) &&
           is_pow2(e) && (e >= MIN_WAYS) &&
           is_pow2(b) && (b >= MIN_BLOCK_BYTES) &&
           is_pow2(rw) && (rw >= MIN_BEAT_BITS) && (rw <= b * 8);
  endfunction

endpackage

// File: rtl/icache_l1_lru.sv
// Age-based LRU state for one cache set. Ages are a permutation of
// 0..E-1; age 0 is most recently used, age E-1 is the replacement candidate.
module icache_l1_lru
  import icache_pkg::*;
#(
  parameter int E = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 init_i,
  input  logic                 touch_i,
  input  logic [$clog2(E)-1:0] touch_way_i,
  input  logic [E-1:0]         valid_i,
  output logic [$clog2(E)-1:0] victim_o
);

  localparam int W = $clog2(E);

  logic [W-1:0] age_q [E];
  logic [W-1:0] touch_age;
  logic         found_invalid;

  assign touch_age = age_q[touch_way_i];

  // Reset/flush restore age[w] = w; a touch makes the way youngest and ages the younger ones.
  always_ff @(posedge clk_i) begin
    if (reset_i || init_i) begin
      for (int i = 0; i < E; i++) begin
        age_q[i] <= W'(i);
      end
    end else if (touch_i) begin
      for (int i = 0; i < E; i++) begin
        if (W'(i) == touch_way_i) begin
          age_q[i] <= '0;
        end else if (age_q[i] < touch_age) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Victim is the lowest invalid way, else the oldest way.
  always_comb begin
    victim_o      = '0;
    found_invalid = 1'b0;
    for (int i = 0; i < E; i++) begin
      if (!valid_i[i] && !found_invalid) begin
        victim_o      = W'(i);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int i = 0; i < E; i++) begin
        if (age_q[i] == W'(E - 1)) begin
          victim_o = W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/icache_l1_gen2.sv
// Set-associative L1 instruction cache with combinational lookup, an
// IDLE/REQ/FILL refill engine fed by beats of RW bits, and fence.i flush.
module icache_l1_gen2
  import icache_pkg::*;
#(
  parameter int S  = 32,
  parameter int E  = 4,
  parameter int B  = 64,
  parameter int RW = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [31:0]   pc_f_i,
  input  logic [1:0]    pc_src_reg_i,
  input  logic          flush_i,
  input  logic          mem_req_ready_i,
  input  logic          rep_valid_i,
  input  logic [RW-1:0] rep_word_i,
  output logic [31:0]   instr_f_o,
  output logic          instr_miss_f_o,
  output logic          instr_cache_rep_active_o,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o
);

  localparam int SI = $clog2(S);
  localparam int BO = $clog2(B);
  localparam int WI = $clog2(E);
  localparam int TW = 32 - SI - BO;
  localparam int NB = (B * 8) / RW;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if (!params_ok(S, E, B, RW)) begin : g_bad_params
    $error("icache_l1_gen2: illegal geometry S=%0d E=%0d B=%0d RW=%0d", S, E, B, RW);
  end

  icache_state_e state_q, next_state;

  logic [B*8-1:0] data_q  [S][E];
  logic [TW-1:0]  tag_q   [S][E];
  logic [E-1:0]   valid_q [S];

  logic [31:0]    miss_addr_q;
  logic [WI-1:0]  victim_q;
  logic [CW-1:0]  cnt_q;
  logic           flush_pend_q;

  logic [TW-1:0]  pc_tag, fill_tag;
  logic [SI-1:0]  pc_set, fill_set, touch_set;
  logic [BO-3:0]  pc_word;
  logic           hit, req_active, fill_last, leave_to_idle, apply_flush, touch_en;
  logic [WI-1:0]  hit_way, touch_way;
  logic [WI-1:0]  set_victim [S];
  logic [B*8-1:0] hit_block;
  logic [31:0]    hit_word;
  logic           unused_pc_bits;

  assign pc_tag         = pc_f_i[31:SI+BO];
  assign pc_set         = pc_f_i[SI+BO-1:BO];
  assign pc_word        = pc_f_i[BO-1:2];
  assign fill_tag       = miss_addr_q[31:SI+BO];
  assign fill_set       = miss_addr_q[SI+BO-1:BO];
  assign unused_pc_bits = ^pc_f_i[1:0];

  // Tag compare across all ways of the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < E; i++) begin
      if (valid_q[pc_set][i] && (tag_q[pc_set][i] == pc_tag)) begin
        hit     = 1'b1;
        hit_way = WI'(i);
      end
    end
  end

  assign hit_block                = data_q[pc_set][hit_way];
  assign hit_word                 = hit_block[int'(pc_word)*INSTR_BITS +: INSTR_BITS];
  assign instr_miss_f_o           = (state_q != IDLE) || !hit;
  assign instr_f_o                = instr_miss_f_o ? '0 : hit_word;
  assign instr_cache_rep_active_o = (state_q != IDLE);
  assign mem_req_o                = req_active && !reset_i;
  assign mem_addr_o               = (req_active && !reset_i) ? miss_addr_q : '0;

  // Refill FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic; acceptance in REQ takes priority over a redirect cancel.
  always_comb begin
    next_state = state_q;
    req_active = 1'b0;
    fill_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit && !flush_i) next_state = REQ;
      end
      REQ: begin
        req_active = 1'b1;
        if (mem_req_ready_i) begin
          next_state = FILL;
        end else if (pc_src_reg_i != 2'b00) begin
          next_state = IDLE;
        end
      end
      FILL: begin
        if (rep_valid_i && (cnt_q == CW'(NB - 1))) begin
          fill_last  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A deferred flush lands on the same edge the FSM returns to IDLE, after the fill's write.
  assign leave_to_idle = (state_q != IDLE) && (next_state == IDLE);
  assign apply_flush   = ((state_q == IDLE) && flush_i) ||
                         (leave_to_idle && (flush_pend_q || flush_i));
  assign touch_en      = fill_last || ((state_q == IDLE) && hit && !flush_i);
  assign touch_set     = fill_last ? fill_set : pc_set;
  assign touch_way     = fill_last ? victim_q : hit_way;

  // Miss bookkeeping: latched address/victim, beat counter and deferred flush flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      miss_addr_q  <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (next_state == REQ)) begin
        miss_addr_q <= {pc_f_i[31:BO], {BO{1'b0}}};
        victim_q    <= set_victim[pc_set];
      end
      if ((state_q == FILL) && rep_valid_i) begin
        cnt_q <= (cnt_q == CW'(NB - 1)) ? '0 : cnt_q + 1'b1;
      end
      if (apply_flush) begin
        flush_pend_q <= 1'b0;
      end else if ((state_q != IDLE) && flush_i) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  // Valid bits: cleared by reset or flush, set when a fill completes.
  always_ff @(posedge clk_i) begin
    if (reset_i || apply_flush) begin
      for (int s = 0; s < S; s++) begin
        valid_q[s] <= '0;
      end
    end else if (fill_last) begin
      valid_q[fill_set][victim_q] <= 1'b1;
    end
  end

  // Data and tag storage, written only by refill and never reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == FILL) && rep_valid_i) begin
      data_q[fill_set][victim_q][int'(cnt_q)*RW +: RW] <= rep_word_i;
    end
    if (!reset_i && fill_last) begin
      tag_q[fill_set][victim_q] <= fill_tag;
    end
  end

  for (genvar g = 0; g < S; g++) begin : g_lru
    icache_l1_lru #(.E(E)) u_lru (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .init_i     (apply_flush),
      .touch_i    (touch_en && (touch_set == SI'(g))),
      .touch_way_i(touch_way),
      .valid_i    (valid_q[g]),
      .victim_o   (set_victim[g])
    );
  end

endmodule

// File: tb/tb_icache_l1_gen2.sv
// Directed self-checking bench for icache_l1_gen2: a 64-bit-beat instance
// for lookup, LRU, cancel, flush and reset cases, plus a 128-bit-beat instance.
module tb_icache_l1_gen2;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic        flush, ready, rep_valid;
  logic [63:0] rep_word;
  logic [31:0] instr, mem_addr;
  logic        miss, active, mem_req;

  logic [31:0]  pc_b;
  logic         ready_b, rep_valid_b;
  logic [127:0] rep_word_b;
  logic [31:0]  instr_b, mem_addr_b;
  logic         miss_b, active_b, mem_req_b;

  int num_checks;
  int num_fail;

  typedef struct {
    logic [31:0] pc;
    logic        exp_miss;
    logic [31:0] exp_instr;
  } lookup_vec_t;

  lookup_vec_t vecs [20];

  icache_l1_gen2 #(.S(32), .E(4), .B(64), .RW(64)) dut (
    .clk_i                   (clk),
    .reset_i                 (reset),
    .pc_f_i                  (pc),
    .pc_src_reg_i            (pc_src),
    .flush_i                 (flush),
    .mem_req_ready_i         (ready),
    .rep_valid_i             (rep_valid),
    .rep_word_i              (rep_word),
    .instr_f_o               (instr),
    .instr_miss_f_o          (miss),
    .instr_cache_rep_active_o(active),
    .mem_req_o               (mem_req),
    .mem_addr_o              (mem_addr)
  );

  icache_l1_gen2 #(.S(32), .E(4), .B(64), .RW(128)) dut_b (
    .clk_i                   (clk),
    .reset_i                 (reset),
    .pc_f_i                  (pc_b),
    .pc_src_reg_i            (2'b00),
    .flush_i                 (1'b0),
    .mem_req_ready_i         (ready_b),
    .rep_valid_i             (rep_valid_b),
    .rep_word_i              (rep_word_b),
    .instr_f_o               (instr_b),
    .instr_miss_f_o          (miss_b),
    .instr_cache_rep_active_o(active_b),
    .mem_req_o               (mem_req_b),
    .mem_addr_o              (mem_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each 32-bit word is derived from its block base and word index.
  function automatic logic [31:0] exp_word(input logic [31:0] base, input int wi);
    return (base ^ 32'hA5A5_0000) + 32'(wi);
  endfunction

  function automatic logic [63:0] beat64(input logic [31:0] base, input int k);
    return {exp_word(base, 2*k+1), exp_word(base, 2*k)};
  endfunction

  function automatic logic [127:0] beat128(input logic [31:0] base, input int k);
    return {exp_word(base, 4*k+3), exp_word(base, 4*k+2), exp_word(base, 4*k+1), exp_word(base, 4*k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] p, input logic [1:0] src, input logic fl,
                               input logic rdy, input logic rv, input logic [63:0] rw);
    pc        = p;
    pc_src    = src;
    flush     = fl;
    ready     = rdy;
    rep_valid = rv;
    rep_word  = rw;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Miss at base, request, acceptance and 8 beats; optional flush pulse on one beat.
  task automatic fill_block(input logic [31:0] base, input int flush_beat);
    applyStimulus(base, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("fill_start_miss", 32'(miss), 32'd1);
    checkOutput("fill_start_noreq", 32'(mem_req), 32'd0);
    tick();
    applyStimulus(base, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("req_valid", 32'(mem_req), 32'd1);
    checkOutput("req_addr", mem_addr, base & 32'hFFFF_FFC0);
    applyStimulus(base, 2'b00, 1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(base, 2'b00, (k == flush_beat), 1'b0, 1'b1, beat64(base, k));
      checkOutput("fill_active", 32'(active), 32'd1);
      checkOutput("fill_busy_miss", 32'(miss), 32'd1);
      tick();
    end
    applyStimulus(base, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("fill_done_idle", 32'(active), 32'd0);
  endtask

  // Lookup expected to hit; the tick lets the hit update LRU.
  task automatic probe_hit(input logic [31:0] p, input logic [31:0] exp);
    applyStimulus(p, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("hit_miss_flag", 32'(miss), 32'd0);
    checkOutput("hit_instr", instr, exp);
    tick();
  endtask

  // Lookup expected to miss; the resulting request is cancelled by a redirect.
  task automatic probe_miss(input logic [31:0] p);
    applyStimulus(p, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("miss_flag", 32'(miss), 32'd1);
    checkOutput("miss_instr_zero", instr, 32'h0);
    tick();
    applyStimulus(p, 2'b01, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("miss_req_state", 32'(active), 32'd1);
    tick();
  endtask

  initial begin
    num_checks  = 0;
    num_fail    = 0;
    reset       = 1'b1;
    pc          = '0;
    pc_src      = '0;
    flush       = 1'b0;
    ready       = 1'b0;
    rep_valid   = 1'b0;
    rep_word    = '0;
    pc_b        = '0;
    ready_b     = 1'b0;
    rep_valid_b = 1'b0;
    rep_word_b  = '0;

    // Reset state
    tick();
    tick();
    applyStimulus(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_active", 32'(active), 32'd0);
    checkOutput("reset_miss", 32'(miss), 32'd1);
    reset = 1'b0;

    // Basic fill of block 0 followed by table-driven lookups
    fill_block(32'h0000_0000, -1);
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{pc: 32'(i*4 + (i % 4)), exp_miss: 1'b0, exp_instr: exp_word(32'h0, i)};
    end
    vecs[16] = '{pc: 32'h0000_0800, exp_miss: 1'b1, exp_instr: 32'h0};
    vecs[17] = '{pc: 32'h0000_0040, exp_miss: 1'b1, exp_instr: 32'h0};
    vecs[18] = '{pc: 32'h0000_003F, exp_miss: 1'b0, exp_instr: exp_word(32'h0, 15)};
    vecs[19] = '{pc: 32'hFFFF_F800, exp_miss: 1'b1, exp_instr: 32'h0};
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].pc, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("table_miss", 32'(miss), 32'(vecs[i].exp_miss));
      checkOutput("table_instr", instr, vecs[i].exp_instr);
      tick();
      if (vecs[i].exp_miss) begin
        applyStimulus(vecs[i].pc, 2'b01, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
      end
    end

    // LRU: fill set 3 with tags 1..4, touch ways 0..2, then tag 5 must evict tag 4
    for (int t = 1; t <= 4; t++) begin
      fill_block(32'(t) * 32'h800 + 32'hC0, -1);
    end
    for (int t = 1; t <= 3; t++) begin
      probe_hit(32'(t) * 32'h800 + 32'hC0, exp_word(32'(t) * 32'h800 + 32'hC0, 0));
    end
    fill_block(32'h0000_28C0, -1);
    probe_hit(32'h0000_28C4, exp_word(32'h0000_28C0, 1));
    probe_miss(32'h0000_20C0);
    probe_hit(32'h0000_08C0, exp_word(32'h0000_08C0, 0));
    probe_hit(32'h0000_18FC, exp_word(32'h0000_18C0, 15));

    // Redirect cancels a pending request; acceptance wins when both arrive together
    applyStimulus(32'h0001_0000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("cancel_first_miss", 32'(miss), 32'd1);
    tick();
    applyStimulus(32'h0001_0000, 2'b01, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("cancel_req_addr", mem_addr, 32'h0001_0000);
    tick();
    applyStimulus(32'h0001_0000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("cancel_back_idle", 32'(active), 32'd0);
    checkOutput("cancel_still_miss", 32'(miss), 32'd1);
    tick();
    applyStimulus(32'h0001_0000, 2'b01, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("accept_req", 32'(mem_req), 32'd1);
    tick();
    applyStimulus(32'h0001_0000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("accept_wins_active", 32'(active), 32'd1);
    checkOutput("accept_wins_noreq", 32'(mem_req), 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(32'h0001_0000, 2'b00, 1'b0, 1'b0, 1'b1, beat64(32'h0001_0000, k));
      tick();
    end
    probe_hit(32'h0001_0014, exp_word(32'h0001_0000, 5));
    probe_hit(32'h0000_0000, exp_word(32'h0, 0));

    // Flush during beat 5: fill completes, then everything misses
    fill_block(32'h0000_2000, 4);
    probe_miss(32'h0000_2000);
    probe_miss(32'h0000_0000);
    probe_miss(32'h0001_0000);
    probe_miss(32'h0000_08C0);
    probe_miss(32'h0000_28C0);

    // Reset during beat 3 abandons the fill; a refetch needs all 8 beats
    applyStimulus(32'h0000_4000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(32'h0000_4000, 2'b00, 1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(32'h0000_4000, 2'b00, 1'b0, 1'b0, 1'b1, beat64(32'h0000_4000, k));
      tick();
    end
    reset = 1'b1;
    applyStimulus(32'h0000_4000, 2'b00, 1'b0, 1'b0, 1'b1, beat64(32'h0000_4000, 2));
    checkOutput("midfill_reset_noreq", 32'(mem_req), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(32'h0000_4000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("midfill_reset_idle", 32'(active), 32'd0);
    checkOutput("midfill_reset_miss", 32'(miss), 32'd1);
    fill_block(32'h0000_4000, -1);
    probe_hit(32'h0000_4000, exp_word(32'h0000_4000, 0));
    probe_hit(32'h0000_403C, exp_word(32'h0000_4000, 15));

    // 128-bit beats with alternating stalls: exactly 4 beats complete the fill
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pc_b = 32'h0;
    #1;
    checkOutput("b_reset_miss", 32'(miss_b), 32'd1);
    tick();
    checkOutput("b_req_valid", 32'(mem_req_b), 32'd1);
    checkOutput("b_req_addr", mem_addr_b, 32'h0);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    for (int c = 0; c < 7; c++) begin
      rep_valid_b = (c % 2 == 0);
      rep_word_b  = beat128(32'h0, c / 2);
      #1;
      checkOutput("b_fill_active", 32'(active_b), 32'd1);
      tick();
    end
    rep_valid_b = 1'b0;
    #1;
    checkOutput("b_fill_done", 32'(active_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pc_b = 32'(i * 4);
      #1;
      checkOutput("b_read_miss", 32'(miss_b), 32'd0);
      checkOutput("b_read_instr", instr_b, exp_word(32'h0, i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
